// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, register-index geometry, and the
// saturating increment used by the optional performance counters.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int PERF_W      = 32;
    localparam int FLUSH_CNT_W = 2;

    // Register 31 reads as zero, so a write to it can never feed a consumer.
    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    // Encoding is visible on hz_state; value 3 is never produced.
    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_FLUSH   = 2'd1,
        HZ_MEMWAIT = 2'd2
    } hz_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        logic [PERF_W-1:0] result;
        if (value == {PERF_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID-stage instruction that reads the
// destination of a load still in EX. The zero register never hazards.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rm,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    logic rn_match_s;
    logic rm_match_s;
    logic ex_load_s;

    // Compare both ID sources against the in-flight load destination.
    always_comb begin
        rn_match_s = (id_rn == ex_rd);
        rm_match_s = id_uses_rm & (id_rm == ex_rd);
        ex_load_s  = ex_valid & ex_mem_read & (ex_rd != XZR_IDX);
        if (ex_load_s && id_valid) begin
            load_use = rn_match_s | rm_match_s;
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decides PC/IF-ID/ID-EX control per cycle
// from memory back-pressure, taken branches and load-use hazards.
// Outputs are combinational from the registered state and the inputs.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall_cycles and
// flush_count outputs; without it those ports and counters are absent.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rm,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 br_taken,
    input  logic                 mem_busy,
    output logic                 pc_we,
    output logic                 ifid_enable,
    output logic                 ifid_valid_in,
    output logic                 idex_bubble,
    output logic                 pipe_freeze,
    output logic [1:0]           hz_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]    stall_cycles,
    output logic [PERF_W-1:0]    flush_count
`endif
);

    // Remaining FLUSH cycles after the squash cycle of a taken branch.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t              state_r;
    hz_state_t              state_nxt_s;
    logic [FLUSH_CNT_W-1:0] flush_cnt_r;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt_s;
    logic                   load_use_s;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rm  (id_uses_rm),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use_s)
    );

    // Per-cycle pipeline controls; priority busy > branch > load-use > normal.
    always_comb begin
        pc_we         = 1'b1;
        ifid_enable   = 1'b1;
        ifid_valid_in = 1'b1;
        idex_bubble   = 1'b0;
        pipe_freeze   = 1'b0;
        hz_state      = state_r;
        if (reset) begin
            pc_we         = 1'b0;
            ifid_enable   = 1'b1;
            ifid_valid_in = 1'b0;
            idex_bubble   = 1'b1;
            pipe_freeze   = 1'b0;
            hz_state      = HZ_RUN;
        end else begin
            case (state_r)
                HZ_RUN, HZ_MEMWAIT: begin
                    if (mem_busy) begin
                        pc_we         = 1'b0;
                        ifid_enable   = 1'b0;
                        ifid_valid_in = 1'b0;
                        idex_bubble   = 1'b0;
                        pipe_freeze   = 1'b1;
                    end else if (br_taken) begin
                        pc_we         = 1'b1;
                        ifid_enable   = 1'b1;
                        ifid_valid_in = 1'b0;
                        idex_bubble   = 1'b1;
                    end else if (load_use_s) begin
                        pc_we         = 1'b0;
                        ifid_enable   = 1'b0;
                        ifid_valid_in = 1'b1;
                        idex_bubble   = 1'b1;
                    end else begin
                        pc_we         = 1'b1;
                        ifid_enable   = 1'b1;
                        ifid_valid_in = 1'b1;
                        idex_bubble   = 1'b0;
                    end
                end
                HZ_FLUSH: begin
                    if (mem_busy) begin
                        pc_we         = 1'b0;
                        ifid_enable   = 1'b0;
                        ifid_valid_in = 1'b0;
                        idex_bubble   = 1'b0;
                        pipe_freeze   = 1'b1;
                    end else begin
                        pc_we         = 1'b1;
                        ifid_enable   = 1'b1;
                        ifid_valid_in = 1'b0;
                        idex_bubble   = 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: hold the PC and inject a bubble
                    // for the single cycle it takes to fall back to RUN.
                    pc_we         = 1'b0;
                    ifid_enable   = 1'b1;
                    ifid_valid_in = 1'b0;
                    idex_bubble   = 1'b1;
                    hz_state      = HZ_RUN;
                end
            endcase
        end
    end

    // Next state and flush counter; FLUSH ignores branches and hazards.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            HZ_RUN, HZ_MEMWAIT: begin
                if (mem_busy) begin
                    state_nxt_s = HZ_MEMWAIT;
                end else if (br_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt_s     = HZ_FLUSH;
                        flush_cnt_nxt_s = FLUSH_LOAD;
                    end else begin
                        state_nxt_s     = HZ_RUN;
                        flush_cnt_nxt_s = 2'd0;
                    end
                end else begin
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_FLUSH: begin
                if (mem_busy) begin
                    state_nxt_s = HZ_FLUSH;
                end else if (flush_cnt_r <= 2'd1) begin
                    state_nxt_s     = HZ_RUN;
                    flush_cnt_nxt_s = 2'd0;
                end else begin
                    state_nxt_s     = HZ_FLUSH;
                    flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s     = HZ_RUN;
                flush_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // State register; reset wins even mid-FLUSH or mid-MEMWAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= HZ_RUN;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic br_accept_s;

    // A branch is accepted only where it is allowed to start a squash.
    assign br_accept_s = ((state_r == HZ_RUN) || (state_r == HZ_MEMWAIT)) &&
                         !mem_busy && br_taken && !reset;

    // Saturating counters of stalled PC cycles and accepted branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!pc_we) begin
                stall_cycles <= sat_inc(stall_cycles);
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (br_accept_s) begin
                flush_count <= sat_inc(flush_count);
            end else begin
                flush_count <= flush_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=3): directed
// scenarios with literal expectations plus randomized traffic compared
// each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, id_uses_rm = 1'b0;
    logic       ex_valid = 1'b0, ex_mem_read = 1'b0;
    logic       br_taken = 1'b0, mem_busy = 1'b0;
    logic [4:0] id_rn = 5'd0, id_rm = 5'd0, ex_rd = 5'd0;
    logic       pc_we, ifid_enable, ifid_valid_in, idex_bubble, pipe_freeze;
    logic [1:0] hz_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_uses_rm    (id_uses_rm),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .br_taken      (br_taken),
        .mem_busy      (mem_busy),
        .pc_we         (pc_we),
        .ifid_enable   (ifid_enable),
        .ifid_valid_in (ifid_valid_in),
        .idex_bubble   (idex_bubble),
        .pipe_freeze   (pipe_freeze),
        .hz_state      (hz_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       pc_we;
        logic       ifid_en;
        logic       ifid_vin;
        logic       bubble;
        logic       freeze;
        logic [1:0] hz;
    } exp_t;

    int          flush_left = 0;   // FLUSH cycles still owed after a squash
    bit          mem_stalled = 0;  // last cycle was a busy freeze outside FLUSH
    logic [31:0] stall_m = 32'd0, flush_m = 32'd0;

    function automatic bit lu_f(input logic ev, input logic mr, input logic [4:0] rd,
                                input logic iv, input logic [4:0] rn, input logic [4:0] rm,
                                input logic urm);
        return ev && mr && (rd != 5'd31) && iv && ((rn == rd) || (urm && rm == rd));
    endfunction

    function automatic exp_t model_out(input bit rst, input bit busy, input bit br,
                                       input bit lu, input int fl, input bit st);
        exp_t e;
        e.hz = rst ? 2'd0 : (fl > 0) ? 2'd1 : st ? 2'd2 : 2'd0;
        if (rst)         {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b01010;
        else if (busy)   {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b00001;
        else if (fl > 0) {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b11000;
        else if (br)     {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b11010;
        else if (lu)     {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b00110;
        else             {e.pc_we, e.ifid_en, e.ifid_vin, e.bubble, e.freeze} = 5'b11100;
        return e;
    endfunction

    bit   lu_s;
    exp_t exp_s;
    assign lu_s  = lu_f(ex_valid, ex_mem_read, ex_rd, id_valid, id_rn, id_rm, id_uses_rm);
    assign exp_s = model_out(reset, mem_busy, br_taken, lu_s, flush_left, mem_stalled);

    // Advance the model on every rising edge.
    always @(posedge clk) begin
        if (reset) begin
            flush_left  <= 0;
            mem_stalled <= 1'b0;
            stall_m     <= 32'd0;
            flush_m     <= 32'd0;
        end else begin
            if (!exp_s.pc_we && stall_m != 32'hFFFF_FFFF) stall_m <= stall_m + 32'd1;
            if (mem_busy) begin
                mem_stalled <= (flush_left == 0);
            end else if (flush_left > 0) begin
                flush_left  <= flush_left - 1;
                mem_stalled <= 1'b0;
            end else begin
                mem_stalled <= 1'b0;
                if (br_taken) begin
                    flush_left <= FC - 1;
                    flush_m    <= flush_m + 32'd1;
                end
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_we", 32'(pc_we), 32'(exp_s.pc_we));
            check("ifid_enable", 32'(ifid_enable), 32'(exp_s.ifid_en));
            if (exp_s.ifid_en) check("ifid_valid_in", 32'(ifid_valid_in), 32'(exp_s.ifid_vin));
            check("idex_bubble", 32'(idex_bubble), 32'(exp_s.bubble));
            check("pipe_freeze", 32'(pipe_freeze), 32'(exp_s.freeze));
            check("hz_state", 32'(hz_state), 32'(exp_s.hz));
`ifdef HAZ_PERF_CNT_EN
            check("stall_cycles", stall_cycles, stall_m);
            check("flush_count", flush_count, flush_m);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input bit r, input bit iv, input logic [4:0] rn, input logic [4:0] rm,
                         input bit urm, input bit ev, input bit mr, input logic [4:0] rd,
                         input bit br, input bit busy);
        @(posedge clk);
        #1;
        reset = r; id_valid = iv; id_rn = rn; id_rm = rm; id_uses_rm = urm;
        ex_valid = ev; ex_mem_read = mr; ex_rd = rd; br_taken = br; mem_busy = busy;
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
    endtask

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 5'd5;
        if (k == 1) return 5'd6;
        if (k == 2) return 5'd31;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        // Reset state
        apply(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        apply(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        check("rst_pc_we", 32'(pc_we), 32'd0);
        check("rst_ifid_en", 32'(ifid_enable), 32'd1);
        check("rst_ifid_vin", 32'(ifid_valid_in), 32'd0);
        check("rst_bubble", 32'(idex_bubble), 32'd1);
        check("rst_freeze", 32'(pipe_freeze), 32'd0);
        check("rst_hz", 32'(hz_state), 32'd0);

        // Load-use on Rn: one stall cycle, then normal
        apply(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        check("lu_pc_we", 32'(pc_we), 32'd0);
        check("lu_ifid_en", 32'(ifid_enable), 32'd0);
        check("lu_bubble", 32'(idex_bubble), 32'd1);
        idle();
        check("lu_after_pc_we", 32'(pc_we), 32'd1);
        check("lu_after_vin", 32'(ifid_valid_in), 32'd1);
        check("lu_after_bubble", 32'(idex_bubble), 32'd0);

        // Load-use on Rm only when Rm is actually read
        apply(1'b0, 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        check("lu_rm_pc_we", 32'(pc_we), 32'd0);
        apply(1'b0, 1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        check("lu_rm_unused_pc_we", 32'(pc_we), 32'd1);

        // XZR never hazards
        apply(1'b0, 1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
        check("xzr_pc_we", 32'(pc_we), 32'd1);
        check("xzr_bubble", 32'(idex_bubble), 32'd0);

        // Taken branch: squash, two FLUSH cycles (hazard ignored), then RUN
        apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        check("br_bubble", 32'(idex_bubble), 32'd1);
        check("br_vin", 32'(ifid_valid_in), 32'd0);
        check("br_pc_we", 32'(pc_we), 32'd1);
        check("br_hz", 32'(hz_state), 32'd0);
        apply(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        check("fl1_hz", 32'(hz_state), 32'd1);
        check("fl1_vin", 32'(ifid_valid_in), 32'd0);
        check("fl1_pc_we", 32'(pc_we), 32'd1);
        check("fl1_bubble", 32'(idex_bubble), 32'd0);
        idle();
        check("fl2_hz", 32'(hz_state), 32'd1);
        check("fl2_vin", 32'(ifid_valid_in), 32'd0);
        idle();
        check("fl_done_hz", 32'(hz_state), 32'd0);
        check("fl_done_vin", 32'(ifid_valid_in), 32'd1);

        // Branch held during 4 busy cycles, squash on cycle 5
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
            check("busy_freeze", 32'(pipe_freeze), 32'd1);
            check("busy_pc_we", 32'(pc_we), 32'd0);
            check("busy_bubble", 32'(idex_bubble), 32'd0);
            check("busy_hz", 32'(hz_state), (i == 0) ? 32'd0 : 32'd2);
        end
        apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        check("bb_hz", 32'(hz_state), 32'd2);
        check("bb_bubble", 32'(idex_bubble), 32'd1);
        check("bb_pc_we", 32'(pc_we), 32'd1);
        check("bb_freeze", 32'(pipe_freeze), 32'd0);
        idle();
        check("bb_flush_hz", 32'(hz_state), 32'd1);
        idle();
        idle();

        // Reset while FLUSH counter is 1
        apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        idle();
        apply(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        check("rmf_hz", 32'(hz_state), 32'd0);
        check("rmf_pc_we", 32'(pc_we), 32'd0);
        check("rmf_bubble", 32'(idex_bubble), 32'd1);
        idle();
        check("rmf_after_hz", 32'(hz_state), 32'd0);
        check("rmf_after_vin", 32'(ifid_valid_in), 32'd1);
        check("rmf_after_bubble", 32'(idex_bubble), 32'd0);

        // Three load-use stalls plus two branches after reset
        apply(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
            idle();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
            idle();
            idle();
            idle();
        end
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall", stall_cycles, 32'd3);
        check("perf_flush", flush_count, 32'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            apply(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  pick_reg(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        idle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter FLUSH_CYCLES, default 1: squash cycles after a taken branch, legal range 1..3.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- id_valid  in  1  ID-stage instruction valid, from IF/ID valid_out
- id_rn  in  5  ID source register Rn
- id_rm  in  5  ID source register Rm
- id_uses_rm  in  1  ID instruction reads Rm
- ex_valid  in  1  EX-stage instruction valid
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- br_taken  in  1  taken branch resolved in EX
- mem_busy  in  1  data memory not ready
- pc_we  out  1  PC write enable
- ifid_enable  out  1  IF/ID register enable
- ifid_valid_in  out  1  valid bit written into IF/ID
- idex_bubble  out  1  force ID/EX valid to 0
- pipe_freeze  out  1  hold every pipeline register
- hz_state  out  2  current FSM state

Function
REQ-004 load_use SHALL be ex_valid & ex_mem_read & (ex_rd != 31) & id_valid & (id_rn == ex_rd | (id_uses_rm & id_rm == ex_rd)).
REQ-005 Register 31 (XZR) SHALL never create a hazard.
REQ-006 FSM states SHALL be RUN, FLUSH and MEMWAIT. Outputs are combinational from state and inputs; state changes only on clk.
REQ-007 Input priority in RUN and MEMWAIT SHALL be mem_busy > br_taken > load_use > normal.
REQ-008 mem_busy=1 in any state SHALL give pipe_freeze=1, pc_we=0, ifid_enable=0, idex_bubble=0, and hold the flush counter. Next state: MEMWAIT from RUN or MEMWAIT; FLUSH stays FLUSH.
REQ-009 br_taken (no mem_busy), in RUN or MEMWAIT, SHALL give:
- outputs pc_we=1, ifid_enable=1, ifid_valid_in=0, idex_bubble=1
- next state FLUSH with counter loaded to FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-010 load_use (no mem_busy, no br_taken) SHALL give pc_we=0, ifid_enable=0, idex_bubble=1 for exactly that cycle; next state RUN.
REQ-011 Normal cycle SHALL give pc_we=1, ifid_enable=1, ifid_valid_in=1, idex_bubble=0, pipe_freeze=0; next state RUN.
REQ-012 FLUSH (no mem_busy) SHALL give:
- outputs pc_we=1, ifid_enable=1, ifid_valid_in=0, idex_bubble=0
- counter decrement; return to RUN when the counter reaches 0
- br_taken and load_use ignored.
REQ-013 MEMWAIT with mem_busy=0 SHALL apply the RUN rules in the same cycle, with no extra dead cycle.
REQ-014 hz_state encoding SHALL be RUN=0, FLUSH=1, MEMWAIT=2; 3 is unreachable and SHALL recover to RUN on the next clk.

Reset
REQ-015 While reset=1, outputs SHALL be pc_we=0, ifid_enable=1, ifid_valid_in=0, idex_bubble=1, pipe_freeze=0, hz_state=RUN.
REQ-016 Reset SHALL clear the state to RUN and the counter to 0, including mid-FLUSH or mid-MEMWAIT; the first post-reset cycle follows RUN rules.

Configuration
REQ-017 With macro HAZ_PERF_CNT_EN defined, the block SHALL add two outputs, both cleared by reset and saturating at 2^32-1:
- stall_cycles, 32 bits: +1 per cycle with pc_we=0 and reset=0
- flush_count, 32 bits: +1 per accepted br_taken (REQ-009).
REQ-018 Without HAZ_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-019 Package pipe_ctrl_pkg SHALL hold hz_state_t, constant XZR_IDX=31 and REG_IDX_W=5.
REQ-020 Load-use comparison SHALL live in a combinational sub-module hazard_detect; the FSM and counters stay in pipe_hazard_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load-use: ex_mem_read=1, ex_rd=5, id_rn=5, both valid -> one cycle of pc_we=0, ifid_enable=0, idex_bubble=1, then normal.
- XZR: ex_rd=31, id_rn=31, load in EX -> no stall, pc_we=1.
- Taken branch, FLUSH_CYCLES=3: br_taken pulse -> squash cycle with idex_bubble=1, then 2 FLUSH cycles with ifid_valid_in=0, then RUN.
- Branch plus busy: mem_busy=1 for 4 cycles with br_taken=1 -> freeze 4 cycles in MEMWAIT, then branch squash on cycle 5.
- Reset mid-FLUSH: reset at counter=1 -> hz_state=0 next cycle, outputs per REQ-015, no residual squash.
- With HAZ_PERF_CNT_EN: 3 load-use stalls plus 2 branches -> stall_cycles=3, flush_count=2.
